// File: rtl/alpha_blend_pipe.sv
// Three-stage alpha blender: foreground A over background B with per-pixel alpha/mode.
// A single global advance enable stalls every stage together; the sideband rides along with its pixel.
module alpha_blend_pipe #(
    parameter int              CW  = 4,
    parameter int              AW  = 2,
    parameter int              SW  = 3,
    parameter logic [3*CW-1:0] KEY = 12'hF0F
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [3*CW-1:0] a_in,
    input  logic [3*CW-1:0] b_in,
    input  logic [AW:0]     alpha_in,
    input  logic [1:0]      mode_in,
    input  logic [SW-1:0]   side_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [3*CW-1:0] pixel_out,
    output logic [SW-1:0]   side_out
);
    localparam int          PW   = 3 * CW;
    localparam int          MW   = CW + AW + 1;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic en;

    logic                 s1_valid_q, s1_valid_d;
    logic [PW-1:0]        s1_a_q, s1_a_d;
    logic [PW-1:0]        s1_b_q, s1_b_d;
    logic [AW:0]          s1_al_q, s1_al_d;
    logic [AW:0]          s1_bl_q, s1_bl_d;
    logic [SW-1:0]        s1_side_q, s1_side_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [2:0][MW-1:0]   s2_pa_q, s2_pa_d;
    logic [2:0][MW-1:0]   s2_pb_q, s2_pb_d;
    logic [SW-1:0]        s2_side_q, s2_side_d;

    logic                 valid_out_q, valid_out_d;
    logic [PW-1:0]        pixel_q, pixel_d;
    logic [SW-1:0]        side_q, side_d;

    logic [AW:0]          al_c;

    // Output register frees up either when empty or when downstream takes the beat.
    assign en        = ~valid_out_q | ready_in;
    assign ready_out = en;
    assign valid_out = valid_out_q;
    assign pixel_out = pixel_q;
    assign side_out  = side_q;

    // Mode decides the effective foreground weight; blend mode clamps alpha to full scale.
    always_comb begin
        al_c = (alpha_in > FULL) ? FULL : alpha_in;
        case (mode_in)
            2'd1:    al_c = FULL;
            2'd2:    al_c = '0;
            2'd3:    al_c = (a_in == KEY) ? '0 : FULL;
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_al_d     = s1_al_q;
        s1_bl_d     = s1_bl_q;
        s1_side_d   = s1_side_q;
        s2_valid_d  = s2_valid_q;
        s2_pa_d     = s2_pa_q;
        s2_pb_d     = s2_pb_q;
        s2_side_d   = s2_side_q;
        valid_out_d = valid_out_q;
        pixel_d     = pixel_q;
        side_d      = side_q;
        if (en) begin
            s1_valid_d  = valid_in;
            s1_a_d      = a_in;
            s1_b_d      = b_in;
            s1_al_d     = al_c;
            s1_bl_d     = FULL - al_c;
            s1_side_d   = side_in;
            s2_valid_d  = s1_valid_q;
            s2_side_d   = s1_side_q;
            for (int c = 0; c < 3; c++) begin
                s2_pa_d[c] = MW'(s1_a_q[c*CW +: CW]) * MW'(s1_al_q);
                s2_pb_d[c] = MW'(s1_b_q[c*CW +: CW]) * MW'(s1_bl_q);
            end
            valid_out_d = s2_valid_q;
            // Output data only moves for real beats so bubbles leave the last pixel visible.
            if (s2_valid_q) begin
                for (int c = 0; c < 3; c++) begin
                    pixel_d[c*CW +: CW] = CW'((s2_pa_q[c] + s2_pb_q[c]) >> AW);
                end
                side_d = s2_side_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_al_q     <= '0;
            s1_bl_q     <= '0;
            s1_side_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_pa_q     <= '0;
            s2_pb_q     <= '0;
            s2_side_q   <= '0;
            valid_out_q <= 1'b0;
            pixel_q     <= '0;
            side_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_al_q     <= s1_al_d;
            s1_bl_q     <= s1_bl_d;
            s1_side_q   <= s1_side_d;
            s2_valid_q  <= s2_valid_d;
            s2_pa_q     <= s2_pa_d;
            s2_pb_q     <= s2_pb_d;
            s2_side_q   <= s2_side_d;
            valid_out_q <= valid_out_d;
            pixel_q     <= pixel_d;
            side_q      <= side_d;
        end
    end
endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Bench for alpha_blend_pipe: scenario tasks drive beats, a monitor records output handshakes,
// and each task compares the recorded stream against a plain-arithmetic blend model.
module tb_alpha_blend_pipe;
    localparam int             CW  = 4;
    localparam int             AW  = 2;
    localparam int             SW  = 3;
    localparam int             PW  = 3 * CW;
    localparam int             EW  = PW + SW;
    localparam logic [PW-1:0]  KEY = 12'hF0F;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          valid_in;
    logic          ready_out;
    logic [PW-1:0] a_in;
    logic [PW-1:0] b_in;
    logic [AW:0]   alpha_in;
    logic [1:0]    mode_in;
    logic [SW-1:0] side_in;
    logic          valid_out;
    logic          ready_in;
    logic [PW-1:0] pixel_out;
    logic [SW-1:0] side_out;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int            acc_cyc_q[$];
    int            got_cyc_q[$];

    alpha_blend_pipe #(.CW(CW), .AW(AW), .SW(SW), .KEY(KEY)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .a_in     (a_in),
        .b_in     (b_in),
        .alpha_in (alpha_in),
        .mode_in  (mode_in),
        .side_in  (side_in),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .pixel_out(pixel_out),
        .side_out (side_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Output handshake is recorded mid-cycle, after inputs settled at posedge+1.
    always @(negedge clk_in) begin
        if (!rst_in && valid_out && ready_in) begin
            got_q.push_back({side_out, pixel_out});
            got_cyc_q.push_back(cyc);
        end
    end

    // Reference: weight = min(alpha, full), overridden by mode; channel = (a*w + b*(full-w)) / full.
    function automatic logic [PW-1:0] ref_blend(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                                input int alpha, input int mode);
        int full;
        int al;
        int ac;
        int bc;
        logic [PW-1:0] r;
        full = 1 << AW;
        al   = (alpha > full) ? full : alpha;
        if (mode == 1) al = full;
        else if (mode == 2) al = 0;
        else if (mode == 3) al = (a == KEY) ? 0 : full;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            ac = int'(a[c*CW +: CW]);
            bc = int'(b[c*CW +: CW]);
            r[c*CW +: CW] = CW'((ac * al + bc * (full - al)) / full);
        end
        return r;
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        acc_cyc_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic idle();
        valid_in = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic send_beat(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [AW:0] alpha,
                             input logic [1:0] mode, input logic [SW-1:0] side);
        bit acc;
        valid_in = 1'b1;
        a_in     = a;
        b_in     = b;
        alpha_in = alpha;
        mode_in  = mode;
        side_in  = side;
        exp_q.push_back({side, ref_blend(a, b, int'(alpha), int'(mode))});
        acc = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_in);
            if (ready_out) begin
                acc_cyc_q.push_back(cyc);
                acc = 1'b1;
            end
            @(posedge clk_in);
            #1;
            if (acc) break;
        end
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 300 && got_q.size() < n; k++) @(posedge clk_in);
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        alpha_in = '0;
        mode_in  = '0;
        side_in  = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out got=%b exp=0", valid_out); else passes++;
        checks++; if (pixel_out !== '0) $display("FAIL reset_pixel_out got=%h exp=000", pixel_out); else passes++;
        checks++; if (side_out !== '0) $display("FAIL reset_side_out got=%h exp=0", side_out); else passes++;
        checks++; if (ready_out !== 1'b1) $display("FAIL reset_ready_out got=%b exp=1", ready_out); else passes++;
        @(posedge clk_in);
        #1;
        ready_in = 1'b1;
    endtask

    task automatic test_alpha_sweep();
        logic [PW-1:0] want [0:4];
        want = '{12'hFFF, 12'hFBB, 12'hF77, 12'hF33, 12'hF00};
        clear_queues();
        for (int i = 0; i < 5; i++) send_beat(12'hF00, 12'hFFF, 3'(i), 2'd0, 3'(i));
        idle();
        wait_out(5);
        checks++; if (got_q.size() != 5) $display("FAIL sweep_count got=%0d exp=5", got_q.size()); else passes++;
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][PW-1:0] !== want[i]) $display("FAIL sweep_pixel[%0d] got=%h exp=%h", i, got_q[i][PW-1:0], want[i]);
            else passes++;
            checks++;
            if (got_cyc_q[i] - acc_cyc_q[i] != 3)
                $display("FAIL sweep_latency[%0d] got=%0d exp=3", i, got_cyc_q[i] - acc_cyc_q[i]);
            else passes++;
        end
    endtask

    task automatic test_clamp();
        clear_queues();
        for (int i = 5; i < 8; i++) send_beat(12'hF00, 12'hFFF, 3'(i), 2'd0, 3'(i));
        idle();
        wait_out(3);
        checks++; if (got_q.size() != 3) $display("FAIL clamp_count got=%0d exp=3", got_q.size()); else passes++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][PW-1:0] !== 12'hF00) $display("FAIL clamp_pixel[%0d] got=%h exp=f00", i, got_q[i][PW-1:0]);
            else passes++;
        end
    endtask

    task automatic test_modes();
        logic [PW-1:0] want_q[$];
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [1:0]    m;
        clear_queues();
        send_beat(12'hF0F, 12'h123, 3'($urandom_range(0, 7)), 2'd3, 3'd1);
        want_q.push_back(12'h123);
        send_beat(12'hF0E, 12'h123, 3'($urandom_range(0, 7)), 2'd3, 3'd2);
        want_q.push_back(12'hF0E);
        for (int i = 0; i < 8; i++) begin
            a = PW'($urandom);
            b = PW'($urandom);
            m = (i % 2 == 0) ? 2'd1 : 2'd2;
            send_beat(a, b, 3'($urandom_range(0, 7)), m, 3'(i));
            want_q.push_back((m == 2'd1) ? a : b);
        end
        idle();
        wait_out(10);
        checks++; if (got_q.size() != 10) $display("FAIL modes_count got=%0d exp=10", got_q.size()); else passes++;
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][PW-1:0] !== want_q[i]) $display("FAIL modes_pixel[%0d] got=%h exp=%h", i, got_q[i][PW-1:0], want_q[i]);
            else passes++;
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL modes_model[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] a;
        clear_queues();
        for (int i = 0; i < 24; i++) begin
            a = (i % 3 == 0) ? KEY : PW'($urandom);
            send_beat(a, PW'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom));
        end
        idle();
        wait_out(24);
        checks++; if (got_q.size() != 24) $display("FAIL b2b_count got=%0d exp=24", got_q.size()); else passes++;
        for (int i = 0; i < 24 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            else passes++;
            checks++;
            if (got_cyc_q[i] - acc_cyc_q[i] != 3)
                $display("FAIL b2b_latency[%0d] got=%0d exp=3", i, got_cyc_q[i] - acc_cyc_q[i]);
            else passes++;
            if (i > 0) begin
                checks++;
                if (got_cyc_q[i] - got_cyc_q[i-1] != 1)
                    $display("FAIL b2b_rate[%0d] got_gap=%0d exp=1", i, got_cyc_q[i] - got_cyc_q[i-1]);
                else passes++;
            end
        end
    endtask

    task automatic test_stall_sideband();
        logic [PW-1:0] cap_pix;
        logic [SW-1:0] cap_side;
        clear_queues();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat(PW'($urandom), PW'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'(i));
                idle();
            end
            begin
                repeat (5) @(posedge clk_in);
                #1;
                ready_in = 1'b0;
                cap_pix  = '0;
                cap_side = '0;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk_in);
                    checks++; if (ready_out !== 1'b0) $display("FAIL stall_ready_out[%0d] got=%b exp=0", s, ready_out); else passes++;
                    checks++; if (valid_out !== 1'b1) $display("FAIL stall_valid_out[%0d] got=%b exp=1", s, valid_out); else passes++;
                    if (s == 0) begin
                        cap_pix  = pixel_out;
                        cap_side = side_out;
                    end else begin
                        checks++; if (pixel_out !== cap_pix) $display("FAIL stall_pixel_hold[%0d] got=%h exp=%h", s, pixel_out, cap_pix); else passes++;
                        checks++; if (side_out !== cap_side) $display("FAIL stall_side_hold[%0d] got=%h exp=%h", s, side_out, cap_side); else passes++;
                    end
                end
                @(posedge clk_in);
                #1;
                ready_in = 1'b1;
            end
        join
        wait_out(8);
        checks++; if (got_q.size() != 8) $display("FAIL stall_count got=%0d exp=8", got_q.size()); else passes++;
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL stall_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            else passes++;
            checks++;
            if (got_q[i][EW-1:PW] !== 3'(i)) $display("FAIL stall_side[%0d] got=%0d exp=%0d", i, got_q[i][EW-1:PW], i);
            else passes++;
        end
    endtask

    task automatic test_random_backpressure();
        bit done;
        done = 1'b0;
        clear_queues();
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send_beat(PW'($urandom), PW'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom));
                idle();
                wait_out(30);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_in);
                    #1;
                    if (!done) ready_in = 1'($urandom_range(0, 1));
                end
                ready_in = 1'b1;
            end
        join
        wait_out(30);
        checks++; if (got_q.size() != 30) $display("FAIL bp_count got=%0d exp=30", got_q.size()); else passes++;
        for (int i = 0; i < 30 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_midstream();
        int n0;
        clear_queues();
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(12'hF00, 12'hFFF, 3'd2, 2'd0, 3'(i + 1));
        rst_in   = 1'b1;
        valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (valid_out !== 1'b0) $display("FAIL midrst_valid_out got=%b exp=0", valid_out); else passes++;
        checks++; if (ready_out !== 1'b1) $display("FAIL midrst_ready_out got=%b exp=1", ready_out); else passes++;
        checks++; if (pixel_out !== '0) $display("FAIL midrst_pixel_out got=%h exp=000", pixel_out); else passes++;
        checks++; if (side_out !== '0) $display("FAIL midrst_side_out got=%h exp=0", side_out); else passes++;
        n0 = got_q.size();
        repeat (8) @(posedge clk_in);
        #1;
        checks++; if (got_q.size() != n0) $display("FAIL midrst_stale got=%0d exp=%0d", got_q.size(), n0); else passes++;
        clear_queues();
        send_beat(12'h0F0, 12'h00F, 3'd1, 2'd0, 3'd5);
        idle();
        wait_out(1);
        checks++; if (got_q.size() != 1) $display("FAIL midrst_new_count got=%0d exp=1", got_q.size()); else passes++;
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_q[0]) $display("FAIL midrst_new_data got=%h exp=%h", got_q[0], exp_q[0]);
            else passes++;
            checks++;
            if (got_cyc_q[0] - acc_cyc_q[0] != 3)
                $display("FAIL midrst_new_latency got=%0d exp=3", got_cyc_q[0] - acc_cyc_q[0]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_alpha_sweep();
        test_clamp();
        test_modes();
        test_back_to_back();
        test_stall_sideband();
        test_random_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
